hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Read-after-write hazard controller for the decode stage. Tracks in-flight register writes per architectural register (r0–r7) between decode issue and writeback. Stalls decode while a source or destination register is unsafe. Credits the same-cycle writeback bypass of the register file, so a source whose last pending write retires this cycle does not stall.

## Interface

**Parameters**
- `MAX_INFLIGHT`, default 3: maximum outstanding writes tracked per register. Legal range 1–3.
- `CNT_W`, default 2: width of each per-register pending counter. Must hold `MAX_INFLIGHT`.

**Ports** (clock and reset first)
- `clk`, in, 1: single clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `dec_valid`, in, 1: decode holds a valid instruction.
- `dec_rs_en`, in, 1: instruction reads `dec_rs` (instruction[10:8]).
- `dec_rs`, in, 3: first source register.
- `dec_rt_en`, in, 1: instruction reads `dec_rt` (instruction[7:5]).
- `dec_rt`, in, 3: second source register.
- `dec_wr_en`, in, 1: instruction writes a register (decoder regwrt).
- `dec_wr`, in, 3: destination register (regdst-mux output).
- `wb_valid`, in, 1: writeback retires a register write this cycle.
- `wb_reg`, in, 3: register retired.
- `flush`, in, 1: squash the decode-stage instruction this cycle.
- `stall`, out, 1: hold PC/fetch and decode registers (combinational).
- `issue`, out, 1: decode instruction advances this cycle (combinational).
- `busy`, out, 8: bit i = pending count of ri nonzero (registered state).
- `err`, out, 1: writeback underflow, registered, one-cycle pulse.
- `stall_cycles`, out, 16: saturating count of stalled cycles.

## Operation

**State**
- `cnt[i]` for i = 0..7, each `CNT_W` bits.
- `err` register.
- `stall_cycles` register.

**Retire term**
- `ret[i] = wb_valid & (wb_reg == i)`.

**Source hazard**
- Source register s is hazardous when `cnt[s] > 1`, or when `cnt[s] == 1` and `~ret[s]`.
- When `cnt[s] == 1` and `ret[s]`, the register-file bypass supplies the data, so there is no stall.

**Destination hazard**
- Hazardous when `dec_wr_en & (cnt[dec_wr] == MAX_INFLIGHT) & ~ret[dec_wr]`.

**Outputs**
- `stall = dec_valid & ~flush & (rs hazard & dec_rs_en | rt hazard & dec_rt_en | dest hazard)`.
- `issue = dec_valid & ~flush & ~stall`.
- A flushed instruction neither stalls nor issues, and does not change any counter.

**Counter update per register i** (inc = `issue & dec_wr_en & dec_wr == i`)
- inc & ~ret: `cnt + 1`.
- ~inc & ret & `cnt != 0`: `cnt - 1`.
- inc & ret: unchanged.
- ret & `cnt == 0` & ~inc: stays 0, and `err` is 1 next cycle.
- ret & `cnt == 0` & inc: becomes 0. The retire consumes the increment, and `err` is 1 next cycle.

**Other rules**
- `err` is 0 on every cycle without an underflow; it is not sticky.
- r0 is an ordinary register; there is no hard-wired zero.
- `stall_cycles` increments on every cycle with `stall` = 1 and saturates at 16'hFFFF.
- Counts never exceed `MAX_INFLIGHT`. The destination stall guarantees this.

## Timing

**Reset** (asynchronous, `rst` = 1, effective immediately, not waiting for `clk`)
- All `cnt` = 0, so `busy` = 8'h00.
- `err` = 0.
- `stall_cycles` = 0.
- `stall` and `issue` follow their equations with all counts 0: `stall` = 0, `issue` = `dec_valid & ~flush`.

**Reset mid-operation**
- All pending state is discarded.
- The pipeline is required to be reset by the same `rst`.

**Latency**
- `stall` and `issue` are zero-latency combinational from inputs and current counts.
- Counter, `busy`, `err` and `stall_cycles` changes are visible the cycle after the triggering edge.

**Handshake**
- Decode holds its instruction while `stall` = 1; the scoreboard re-evaluates every cycle.
- `issue` is asserted exactly once per instruction.

**Same-cycle events**
- Issue and retire in one cycle are both applied. Retire is evaluated against pre-update counts.
- An instruction reading and writing the same register checks the source hazard first; if no stall, it increments.

## Test plan

1. Reset with `dec_valid` = 0 → `busy` = 00, `stall` = 0, `err` = 0, `stall_cycles` = 0.
2. Issue a write to r3. Next cycle, issue an instruction reading r3 (rs = 3) with no writeback → `stall` = 1 each cycle. Then assert `wb_valid`/`wb_reg` = 3 → that same cycle `stall` = 0, `issue` = 1, and the next cycle `busy[3]` = 0.
3. Issue three writes to r5 back-to-back (`MAX_INFLIGHT` = 3), then a fourth → the fourth stalls. Retire r5 in the next cycle → the fourth issues in that cycle and `cnt[5]` stays 3.
4. Writeback of r2 with `cnt[2]` = 0 → `err` = 1 for exactly one cycle, `busy[2]` = 0. Repeat with a simultaneous issue writing r2 → `busy[2]` = 0 and `err` = 1.
5. Hazard on r1 plus `flush` = 1 → `stall` = 0, `issue` = 0, counts unchanged.
6. Hold `stall` for 70000 cycles → `stall_cycles` = 16'hFFFF. Then assert `rst` asynchronously between edges → all outputs at reset values before the next `clk` edge.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Read-after-write hazard controller for the decode stage. Keeps a pending
//   write count for each architectural register r0..r7. A count goes up when an
//   instruction that writes the register issues from decode, and goes down when
//   writeback retires that register. Decode stalls while a source register has
//   an outstanding write that is not being retired this cycle, or while the
//   destination register already has MAX_INFLIGHT writes pending.
//
// Ports
//   clk, rst          : clock, asynchronous active-high reset
//   dec_valid         : decode holds a valid instruction
//   dec_rs_en, dec_rs : first source read enable / register
//   dec_rt_en, dec_rt : second source read enable / register
//   dec_wr_en, dec_wr : destination write enable / register
//   wb_valid, wb_reg  : writeback retires a write to wb_reg this cycle
//   flush             : squash the decode-stage instruction this cycle
//   stall             : hold fetch/decode (combinational)
//   issue             : decode instruction advances this cycle (combinational)
//   busy[i]           : register i has at least one pending write
//   err               : one-cycle pulse after a writeback with no pending write
//   stall_cycles      : saturating count of stalled cycles
module hazard_scoreboard #(
  parameter int MAX_INFLIGHT = 3,
  parameter int CNT_W        = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dec_valid,
  input  logic        dec_rs_en,
  input  logic [2:0]  dec_rs,
  input  logic        dec_rt_en,
  input  logic [2:0]  dec_rt,
  input  logic        dec_wr_en,
  input  logic [2:0]  dec_wr,
  input  logic        wb_valid,
  input  logic [2:0]  wb_reg,
  input  logic        flush,
  output logic        stall,
  output logic        issue,
  output logic [7:0]  busy,
  output logic        err,
  output logic [15:0] stall_cycles
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INFLIGHT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt     [8];
  logic [CNT_W-1:0] cnt_nxt [8];
  logic [7:0]       ret;
  logic [7:0]       inc;
  logic             rs_hz;
  logic             rt_hz;
  logic             wr_hz;
  logic             err_nxt;

  // A single pending write that retires this cycle is covered by the
  // register-file write-through bypass, so only older writes block the read.
  function automatic logic src_hazard(input logic [CNT_W-1:0] c, input logic r);
    return (c > CNT_ONE) || ((c == CNT_ONE) && !r);
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // ---- decode-stage hazard evaluation (combinational) ----
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      ret[i] = wb_valid && (wb_reg == 3'(i));
    end
  end

  assign rs_hz = dec_rs_en && src_hazard(cnt[dec_rs], ret[dec_rs]);
  assign rt_hz = dec_rt_en && src_hazard(cnt[dec_rt], ret[dec_rt]);
  // A retire in the same cycle frees a slot, so a full counter may still accept.
  assign wr_hz = dec_wr_en && (cnt[dec_wr] == CNT_MAX) && !ret[dec_wr];

  assign stall = dec_valid && !flush && (rs_hz || rt_hz || wr_hz);
  assign issue = dec_valid && !flush && !stall;

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      inc[i]     = issue && dec_wr_en && (dec_wr == 3'(i));
      cnt_nxt[i] = cnt[i];
      // Retiring against an empty counter while issuing leaves it at 0:
      // the retire consumes the increment.
      if (inc[i] && !ret[i]) begin
        cnt_nxt[i] = cnt[i] + CNT_ONE;
      end else if (!inc[i] && ret[i] && (cnt[i] != '0)) begin
        cnt_nxt[i] = cnt[i] - CNT_ONE;
      end
      busy[i] = (cnt[i] != '0);
    end
  end

  assign err_nxt = wb_valid && (cnt[wb_reg] == '0);

  // ---- scoreboard state register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        cnt[i] <= '0;
      end
      err          <= 1'b0;
      stall_cycles <= 16'd0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
      err <= err_nxt;
      if (stall) begin
        stall_cycles <= sat_inc16(stall_cycles);
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dec_valid = 1'b0;
  logic        dec_rs_en = 1'b0;
  logic [2:0]  dec_rs = 3'd0;
  logic        dec_rt_en = 1'b0;
  logic [2:0]  dec_rt = 3'd0;
  logic        dec_wr_en = 1'b0;
  logic [2:0]  dec_wr = 3'd0;
  logic        wb_valid = 1'b0;
  logic [2:0]  wb_reg = 3'd0;
  logic        flush = 1'b0;
  logic        stall;
  logic        issue;
  logic [7:0]  busy;
  logic        err;
  logic [15:0] stall_cycles;

  hazard_scoreboard #(.MAX_INFLIGHT(3), .CNT_W(2)) dut (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid),
    .dec_rs_en(dec_rs_en), .dec_rs(dec_rs),
    .dec_rt_en(dec_rt_en), .dec_rt(dec_rt),
    .dec_wr_en(dec_wr_en), .dec_wr(dec_wr),
    .wb_valid(wb_valid), .wb_reg(wb_reg),
    .flush(flush),
    .stall(stall), .issue(issue), .busy(busy), .err(err),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic        s;
    logic        i;
    logic [7:0]  b;
    logic        e;
    logic [15:0] sc;
  } exp_t;

  exp_t q[$];
  exp_t mx;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input string f, input logic [15:0] act,
                     input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s.%s actual=%h required=%h", nm, f, act, req);
    end
  endtask

  // Monitor: sample away from the active edge and compare against queued
  // expectations.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      mx = q.pop_front();
      chk(mx.nm, "stall", {15'd0, stall}, {15'd0, mx.s});
      chk(mx.nm, "issue", {15'd0, issue}, {15'd0, mx.i});
      chk(mx.nm, "busy",  {8'd0, busy},   {8'd0, mx.b});
      chk(mx.nm, "err",   {15'd0, err},   {15'd0, mx.e});
      chk(mx.nm, "stall_cycles", stall_cycles, mx.sc);
    end
  end

  task automatic push(input string nm, input int es, input int ei, input int eb,
                      input int ee, input int esc);
    exp_t x;
    x.nm = nm;
    x.s  = 1'(es);
    x.i  = 1'(ei);
    x.b  = 8'(eb);
    x.e  = 1'(ee);
    x.sc = 16'(esc);
    q.push_back(x);
  endtask

  task automatic drive(input int dv, input int rse, input int rs, input int rte,
                       input int rt, input int we, input int wr, input int wbv,
                       input int wbr, input int fl);
    dec_valid = 1'(dv);
    dec_rs_en = 1'(rse);
    dec_rs    = 3'(rs);
    dec_rt_en = 1'(rte);
    dec_rt    = 3'(rt);
    dec_wr_en = 1'(we);
    dec_wr    = 3'(wr);
    wb_valid  = 1'(wbv);
    wb_reg    = 3'(wbr);
    flush     = 1'(fl);
  endtask

  // One cycle: apply inputs just after an edge, queue the expected outputs for
  // this cycle (state values are those left by the previous edge).
  task automatic cyc(input string nm,
                     input int dv, input int rse, input int rs, input int rte,
                     input int rt, input int we, input int wr, input int wbv,
                     input int wbr, input int fl,
                     input int es, input int ei, input int eb, input int ee,
                     input int esc);
    drive(dv, rse, rs, rte, rt, we, wr, wbv, wbr, fl);
    push(nm, es, ei, eb, ee, esc);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    //   name          dv rse rs rte rt we wr wbv wbr fl | st is busy  err sc
    cyc("reset",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0,      0, 0, 'h00, 0, 0);
    rst = 1'b0;
    cyc("idle",        0, 0, 0, 0, 0, 0, 0, 0, 0, 0,      0, 0, 'h00, 0, 0);
    // RAW on r3, resolved by same-cycle writeback bypass
    cyc("wr_r3",       1, 0, 0, 0, 0, 1, 3, 0, 0, 0,      0, 1, 'h00, 0, 0);
    cyc("rs3_stall_a", 1, 1, 3, 0, 0, 0, 0, 0, 0, 0,      1, 0, 'h08, 0, 0);
    cyc("rs3_stall_b", 1, 1, 3, 0, 0, 0, 0, 0, 0, 0,      1, 0, 'h08, 0, 1);
    cyc("rs3_bypass",  1, 1, 3, 0, 0, 0, 0, 1, 3, 0,      0, 1, 'h08, 0, 2);
    cyc("r3_clear",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0,      0, 0, 'h00, 0, 2);
    // Destination limit on r5
    cyc("wr_r5_1",     1, 0, 0, 0, 0, 1, 5, 0, 0, 0,      0, 1, 'h00, 0, 2);
    cyc("wr_r5_2",     1, 0, 0, 0, 0, 1, 5, 0, 0, 0,      0, 1, 'h20, 0, 2);
    cyc("wr_r5_3",     1, 0, 0, 0, 0, 1, 5, 0, 0, 0,      0, 1, 'h20, 0, 2);
    cyc("wr_r5_full",  1, 0, 0, 0, 0, 1, 5, 0, 0, 0,      1, 0, 'h20, 0, 2);
    cyc("wr_r5_ret",   1, 0, 0, 0, 0, 1, 5, 1, 5, 0,      0, 1, 'h20, 0, 3);
    cyc("rt5_stall",   1, 0, 0, 1, 5, 0, 0, 0, 0, 0,      1, 0, 'h20, 0, 3);
    cyc("ret5_a",      0, 0, 0, 0, 0, 0, 0, 1, 5, 0,      0, 0, 'h20, 0, 4);
    cyc("rs5_cnt2_wb", 1, 1, 5, 0, 0, 0, 0, 1, 5, 0,      1, 0, 'h20, 0, 4);
    cyc("rs5_cnt1_wb", 1, 1, 5, 0, 0, 0, 0, 1, 5, 0,      0, 1, 'h20, 0, 5);
    cyc("r5_clear",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0,      0, 0, 'h00, 0, 5);
    // Writeback underflow on r2
    cyc("uf_r2",       0, 0, 0, 0, 0, 0, 0, 1, 2, 0,      0, 0, 'h00, 0, 5);
    cyc("uf_err",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0,      0, 0, 'h00, 1, 5);
    cyc("uf_err_off",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0,      0, 0, 'h00, 0, 5);
    cyc("uf_r2_inc",   1, 0, 0, 0, 0, 1, 2, 1, 2, 0,      0, 1, 'h00, 0, 5);
    cyc("uf_inc_err",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0,      0, 0, 'h00, 1, 5);
    cyc("uf_inc_off",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0,      0, 0, 'h00, 0, 5);
    // Flush over a hazard on r1: no stall, no issue, count untouched
    cyc("wr_r1",       1, 0, 0, 0, 0, 1, 1, 0, 0, 0,      0, 1, 'h00, 0, 5);
    cyc("flush_r1",    1, 1, 1, 0, 0, 1, 1, 0, 0, 1,      0, 0, 'h02, 0, 5);
    cyc("r1_cnt1",     1, 1, 1, 0, 0, 0, 0, 1, 1, 0,      0, 1, 'h02, 0, 5);
    cyc("r1_clear",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0,      0, 0, 'h00, 0, 5);
    // r0 behaves normally; read-and-write of r0 stalls on the source
    cyc("wr_r0",       1, 1, 0, 0, 0, 1, 0, 0, 0, 0,      0, 1, 'h00, 0, 5);
    cyc("rw_r0_stall", 1, 1, 0, 0, 0, 1, 0, 0, 0, 0,      1, 0, 'h01, 0, 5);
    repeat (70000) @(posedge clk);
    #1;
    cyc("sat_a",       1, 1, 0, 0, 0, 1, 0, 0, 0, 0,      1, 0, 'h01, 0, 'hFFFF);
    cyc("sat_b",       1, 1, 0, 0, 0, 1, 0, 0, 0, 0,      1, 0, 'h01, 0, 'hFFFF);
    // Asynchronous reset between edges; checked at the following falling edge
    #1;
    rst = 1'b1;
    push("async_rst", 0, 1, 'h00, 0, 0);
    @(posedge clk);
    #1;
    cyc("rst_flush",   1, 1, 0, 0, 0, 1, 0, 0, 0, 1,      0, 0, 'h00, 0, 0);

    for (int k = 0; k < 20 && q.size() > 0; k++) @(posedge clk);
    if (q.size() > 0) begin
      bad++;
      total++;
      $display("FAIL drain actual=%0d required=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
